// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC default,
// implemented instruction RAM size, and the layout of a queued fetch entry.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IMEM_ADDR_W      = 9;

  // One queued fetch result: {fault, pc, instr}, fault in the MSB.
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // inst_ram is word addressed; the byte offset bits are dropped.
  function automatic logic [31:0] word_adr(input logic [31:0] byte_pc);
    return {2'b00, byte_pc[31:2]};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO holding fetched entries for decode. Supports a
// same-cycle push and pop when full, and a flush that empties it at the
// next posedge (flush wins over push and pop).
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FETCH_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // An empty FIFO presents zeros so the head outputs are clean after reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  // NOTE: clocked state is updated with non-blocking assignments so every
  // register in the block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // empty masks the head, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage upstream of inst_ram: holds the PC, drives the word address,
// captures the returned word and queues {fault, pc, instr} for decode.
// A redirect reloads the PC and flushes everything queued.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = IMEM_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [3:0]  imem_wren,
  output logic [31:0] imem_adr,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  logic [31:0]  pc;
  logic         fault;
  logic         pop;
  logic         issue;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // The instruction port is read-only.
  assign imem_wren  = 4'b0000;
  assign imem_wdata = 32'h0;
  assign imem_adr   = word_adr(pc);

  // Misaligned PCs and PCs beyond the implemented RAM (which would alias) are flagged.
  assign fault = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != 32'd0);

  // A slot frees up this cycle if the head is handed to decode.
  assign pop   = out_valid & out_ready;
  assign issue = fetch_en & ~redirect_valid & (~fifo_full | pop);

  assign push_entry = '{fault: fault, pc: pc, instr: imem_rdata};

  // PC: redirect has priority, otherwise advance by one word per issued fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (issue) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;
  assign out_fault = head_entry.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch with a behavioural inst_ram stand-in (negedge-read,
// Ram[i] = A000_0000 + i) and a queue model of what decode must see.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RAM_BYTES = 32'd2048;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [3:0]  imem_wren;
  logic [31:0] imem_adr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram [512];
  exp_t        q[$];
  logic [31:0] mpc = RESET_PC;

  inst_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .ADDR_W   (9)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_wren      (imem_wren),
    .imem_adr       (imem_adr),
    .imem_wdata     (imem_wdata),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // inst_ram stand-in: address sampled and DataOut registered on negedge, Adr[8:0] only.
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'hA000_0000 + 32'(i);
    forever begin
      @(negedge clk);
      imem_rdata = ram[imem_adr[8:0]];
    end
  end

  // Reference model: what decode must receive, derived from the fetch rules.
  initial begin
    logic m_pop, m_full, m_issue;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        mpc = RESET_PC;
      end else begin
        m_pop   = (q.size() != 0) && out_ready;
        m_full  = (q.size() == DEPTH);
        m_issue = fetch_en && !redirect_valid && (!m_full || m_pop);
        if (redirect_valid) begin
          q.delete();
          mpc = redirect_pc;
        end else begin
          if (m_pop) void'(q.pop_front());
          if (m_issue) begin
            e.pc    = mpc;
            e.instr = 32'hA000_0000 + ((mpc / 4) % 512);
            e.fault = (mpc % 4 != 0) || (mpc >= RAM_BYTES);
            q.push_back(e);
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  // Compare every cycle on the negedge, away from the active edge.
  initial begin
    logic        have_last = 1'b0;
    logic [31:0] last_pc = 32'h0;
    forever begin
      @(negedge clk);
      check("imem_wren", 32'(imem_wren), 32'h0);
      check("imem_wdata", imem_wdata, 32'h0);
      check("imem_adr", imem_adr, {2'b00, mpc[31:2]});
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (!rst_n) begin
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_fault", 32'(out_fault), 32'h0);
        have_last = 1'b0;
      end else begin
        if (q.size() != 0) begin
          check("out_pc", out_pc, q[0].pc);
          check("out_instr", out_instr, q[0].instr);
          check("out_fault", 32'(out_fault), 32'(q[0].fault));
        end
        if (out_valid && out_ready) begin
          if (have_last) check("pc_step", out_pc, last_pc + 32'd4);
          last_pc   = out_pc;
          have_last = 1'b1;
        end
        if (redirect_valid) have_last = 1'b0;
      end
    end
  end

  task automatic drive(input logic fe, input logic rdy,
                       input logic rv = 1'b0, input logic [31:0] rpc = 32'h0);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;

    // 1: back-to-back fetch after reset
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("t1_valid_pre", 32'(out_valid), 32'h0);
    drive(1, 1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_instr0", out_instr, 32'hA000_0000);
    drive(1, 1);
    check("t1_pc1", out_pc, 32'h4);
    check("t1_instr1", out_instr, 32'hA000_0001);
    drive(1, 1);
    check("t1_pc2", out_pc, 32'h8);
    check("t1_instr2", out_instr, 32'hA000_0002);
    repeat (4) drive(1, 1);

    // 2: stall fills the FIFO, release drains in order
    do_reset();
    repeat (5) drive(1, 0);
    check("t2_adr_stall", imem_adr, 32'h2);
    check("t2_head0", out_pc, 32'h0);
    drive(1, 1);
    check("t2_head1", out_pc, 32'h4);
    drive(1, 1);
    check("t2_head2", out_pc, 32'h8);
    drive(1, 1);
    check("t2_head3", out_pc, 32'hC);

    // 3: redirect while full with a same-cycle transfer
    drive(1, 0);
    drive(1, 1, 1, 32'h40);
    check("t3_flushed", 32'(out_valid), 32'h0);
    drive(1, 1);
    check("t3_pc", out_pc, 32'h40);
    check("t3_instr", out_instr, 32'hA000_0010);
    check("t3_fault", 32'(out_fault), 32'h0);

    // 4: misaligned, out-of-range and wrapping PCs
    drive(1, 1, 1, 32'h42);
    drive(1, 1);
    check("t4_mis_pc", out_pc, 32'h42);
    check("t4_mis_instr", out_instr, 32'hA000_0010);
    check("t4_mis_fault", 32'(out_fault), 32'h1);
    drive(1, 1, 1, 32'h800);
    drive(1, 1);
    check("t4_oor_pc", out_pc, 32'h800);
    check("t4_oor_instr", out_instr, 32'hA000_0000);
    check("t4_oor_fault", 32'(out_fault), 32'h1);
    drive(1, 0, 1, 32'hFFFF_FFFC);
    drive(1, 0);
    check("t4_wrap_adr", imem_adr, 32'h0);
    check("t4_top_instr", out_instr, 32'hA000_01FF);
    check("t4_top_fault", 32'(out_fault), 32'h1);
    drive(1, 0);
    drive(1, 1);
    check("t4_wrap_pc", out_pc, 32'h0);
    check("t4_wrap_fault", 32'(out_fault), 32'h0);

    // 5: reset mid-stream with two queued entries
    drive(1, 0);
    rst_n = 1'b0;
    #1;
    check("t5_valid_rst", 32'(out_valid), 32'h0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    drive(1, 1);
    check("t5_restart_pc", out_pc, RESET_PC);
    check("t5_restart_instr", out_instr, 32'hA000_0000);

    // 6: toggling fetch_en with random backpressure and one redirect
    for (int i = 0; i < 60; i++) begin
      if (i == 30) drive(1'(i % 2), 1'($urandom_range(0, 1)), 1, 32'h100);
      else         drive(1'(i % 2), 1'($urandom_range(0, 1)));
    end
    repeat (4) drive(0, 1);
    check("t6_drained", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
